mod_segment_scheduler: RTL and testbench

- Sequences modulation-buffer playback across the two modulation segments.
- Inputs: shadow registers MOD_REQ_RD_SEGMENT, MOD_CYCLE_n, MOD_FREQ_DIV_n and MOD_REP_n, latched on the controller's MOD_SET update pulse.
- Outputs: the active read segment and sample index toward the modulation BRAM read port.
- Handles the divider, loop counting, segment swap timing and the stop-after-N-repeats condition.

---
 rtl/mod_segment_scheduler_if.sv | 29 ++
 rtl/mod_segment_scheduler.sv | 104 ++++++++++
 tb/tb_mod_segment_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mod_segment_scheduler_if.sv
// mod_segment_scheduler_if: configuration shadow registers in, BRAM read position and status out.
interface mod_segment_scheduler_if #(
    parameter int CYCLE_W = 16,
    parameter int DIV_W   = 32,
    parameter int REP_W   = 32
);
    logic               update;
    logic               tick;
    logic               req_segment;
    logic [CYCLE_W-1:0] cycle_0;
    logic [CYCLE_W-1:0] cycle_1;
    logic [DIV_W-1:0]   freq_div_0;
    logic [DIV_W-1:0]   freq_div_1;
    logic [REP_W-1:0]   rep_0;
    logic [REP_W-1:0]   rep_1;
    logic               segment;
    logic [CYCLE_W-1:0] idx;
    logic               idx_step;
    logic               stopped;
    logic               swap_pending;
    modport master (
        output update, tick, req_segment, cycle_0, cycle_1, freq_div_0, freq_div_1, rep_0, rep_1,
        input  segment, idx, idx_step, stopped, swap_pending
    );
    modport slave (
        input  update, tick, req_segment, cycle_0, cycle_1, freq_div_0, freq_div_1, rep_0, rep_1,
        output segment, idx, idx_step, stopped, swap_pending
    );
endinterface

// File: rtl/mod_segment_scheduler.sv
// mod_segment_scheduler: steps the modulation sample index through two segments with
// per-segment divider, loop count, deferred segment swap and stop-after-N-repeats.
module mod_segment_scheduler #(
    parameter int CYCLE_W = 16,
    parameter int DIV_W   = 32,
    parameter int REP_W   = 32
) (
    input logic clk,
    input logic rst,
    mod_segment_scheduler_if.slave bus
);
    typedef enum logic [1:0] {RUN, WAIT_WRAP, STOP} state_t;
    state_t state, n_state;
    logic seg, n_seg, pend, n_pend, step, n_step;
    logic [CYCLE_W-1:0] idx, n_idx;
    logic [DIV_W-1:0] div_cnt, n_div, div_sel, dlim;
    logic [REP_W-1:0] loop_cnt, n_loop;
    logic [1:0][CYCLE_W-1:0] cyc;
    logic [1:0][DIV_W-1:0] fdiv;
    logic [1:0][REP_W-1:0] rep;
    logic count_en, term, wrap, do_swap;
    // While stopped the only thing left to time is a pending swap, so use the target's divider
    assign div_sel  = (state == STOP) ? fdiv[~seg] : fdiv[seg];
    assign dlim     = (div_sel == '0) ? '0 : div_sel - DIV_W'(1);
    assign count_en = (state != STOP) || pend;
    assign term     = bus.tick && count_en && (div_cnt >= dlim);
    assign wrap     = idx >= cyc[seg];
    assign do_swap  = term && pend && ((state == STOP) || (state == RUN && &rep[~seg]) ||
                      (state == WAIT_WRAP && wrap));
    always_comb begin
        n_state = (state == RUN && pend && !(&rep[~seg])) ? WAIT_WRAP : state;
        n_seg   = seg;
        n_idx   = idx;
        n_loop  = loop_cnt;
        n_pend  = pend;
        n_step  = 1'b0;
        n_div   = (bus.tick && count_en) ? (term ? '0 : div_cnt + DIV_W'(1)) : div_cnt;
        if (do_swap) begin
            n_seg   = ~seg;
            n_idx   = '0;
            n_div   = '0;
            n_loop  = '0;
            n_pend  = 1'b0;
            n_state = RUN;
            n_step  = 1'b1;
        end else if (term && state != STOP) begin
            if (!wrap) begin
                n_idx  = idx + CYCLE_W'(1);
                n_step = 1'b1;
            end else if (!(&rep[seg]) && loop_cnt == rep[seg]) begin
                n_state = STOP;
            end else begin
                n_idx  = '0;
                n_loop = loop_cnt + REP_W'(1);
                n_step = 1'b1;
            end
        end
        // Re-requesting the active segment restarts it and cancels any pending swap
        if (bus.update) begin
            if (bus.req_segment == n_seg) begin
                n_pend  = 1'b0;
                n_state = RUN;
                n_idx   = '0;
                n_div   = '0;
                n_loop  = '0;
                n_step  = 1'b1;
            end else begin
                n_pend = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            seg      <= 1'b0;
            idx      <= '0;
            div_cnt  <= '0;
            loop_cnt <= '0;
            pend     <= 1'b0;
            step     <= 1'b0;
            cyc      <= '0;
            fdiv     <= '0;
            rep      <= '0;
        end else begin
            state    <= n_state;
            seg      <= n_seg;
            idx      <= n_idx;
            div_cnt  <= n_div;
            loop_cnt <= n_loop;
            pend     <= n_pend;
            step     <= n_step;
            if (bus.update) begin
                cyc  <= {bus.cycle_1, bus.cycle_0};
                fdiv <= {bus.freq_div_1, bus.freq_div_0};
                rep  <= {bus.rep_1, bus.rep_0};
            end
        end
    end
    assign bus.segment      = seg;
    assign bus.idx          = idx;
    assign bus.idx_step     = step;
    assign bus.stopped      = state == STOP;
    assign bus.swap_pending = pend;
endmodule

// File: tb/tb_mod_segment_scheduler.sv
// tb_mod_segment_scheduler: directed vectors against hand-computed index/segment/status values.
module tb_mod_segment_scheduler;
    localparam logic [31:0] INF = 32'hFFFF_FFFF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vec = 0;
    int err = 0;
    int steps;
    mod_segment_scheduler_if bus ();
    mod_segment_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic idle();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_tick();
        bus.tick = 1'b1;
        idle();
        bus.tick = 1'b0;
    endtask
    task automatic upd(input logic r, input logic t, input logic [15:0] c0, input logic [31:0] d0,
                       input logic [31:0] r0, input logic [15:0] c1, input logic [31:0] d1,
                       input logic [31:0] r1);
        bus.req_segment = r;
        bus.cycle_0 = c0;
        bus.freq_div_0 = d0;
        bus.rep_0 = r0;
        bus.cycle_1 = c1;
        bus.freq_div_1 = d1;
        bus.rep_1 = r1;
        bus.update = 1'b1;
        bus.tick = t;
        idle();
        bus.update = 1'b0;
        bus.tick = 1'b0;
    endtask
    task automatic do_reset();
        #2 rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, " seg"}, bus.segment, 0);
        chk({tag, " idx"}, bus.idx, 0);
        chk({tag, " step"}, bus.idx_step, 0);
        chk({tag, " stopped"}, bus.stopped, 0);
        chk({tag, " pend"}, bus.swap_pending, 0);
    endtask
    initial begin
        int exp2 [10] = '{1, 2, 3, 0, 1, 2, 3, 3, 3, 3};
        bus.update = 0; bus.tick = 0; bus.req_segment = 0;
        bus.cycle_0 = 0; bus.cycle_1 = 0; bus.freq_div_0 = 0; bus.freq_div_1 = 0;
        bus.rep_0 = 0; bus.rep_1 = 0;
        idle();
        chk_zero("reset");
        rst = 1'b0;
        // infinite loop, divide by 2
        upd(0, 0, 3, 2, INF, 0, 0, 0);
        chk("t1 restart step", bus.idx_step, 1);
        for (int k = 1; k <= 16; k++) begin
            pulse_tick();
            chk($sformatf("t1 idx k=%0d", k), bus.idx, (k / 2) % 4);
        end
        chk("t1 stopped", bus.stopped, 0);
        // two loops then stop
        upd(0, 0, 3, 1, 1, 0, 0, 0);
        steps = 0;
        for (int k = 0; k < 10; k++) begin
            pulse_tick();
            steps += int'(bus.idx_step);
            chk($sformatf("t2 idx k=%0d", k), bus.idx, exp2[k]);
        end
        chk("t2 stopped", bus.stopped, 1);
        chk("t2 step count", steps, 7);
        // swap to infinite target at next step
        upd(0, 0, 7, 1, INF, 4, 1, INF);
        chk("t3 restart clears stop", bus.stopped, 0);
        pulse_tick();
        pulse_tick();
        chk("t3 idx", bus.idx, 2);
        upd(1, 0, 7, 1, INF, 4, 1, INF);
        chk("t3 pend", bus.swap_pending, 1);
        chk("t3 seg before", bus.segment, 0);
        chk("t3 no step", bus.idx_step, 0);
        pulse_tick();
        chk("t3 seg after", bus.segment, 1);
        chk("t3 idx after", bus.idx, 0);
        chk("t3 pend after", bus.swap_pending, 0);
        chk("t3 step", bus.idx_step, 1);
        // finite target waits for wrap, then plays once and stops
        do_reset();
        upd(0, 0, 7, 1, INF, 4, 1, 0);
        pulse_tick();
        pulse_tick();
        upd(1, 0, 7, 1, INF, 4, 1, 0);
        chk("t4 pend", bus.swap_pending, 1);
        for (int k = 3; k <= 7; k++) begin
            pulse_tick();
            chk($sformatf("t4 seg0 idx %0d", k), bus.idx, k);
            chk($sformatf("t4 seg0 seg %0d", k), bus.segment, 0);
        end
        pulse_tick();
        chk("t4 swap seg", bus.segment, 1);
        chk("t4 swap idx", bus.idx, 0);
        chk("t4 swap pend", bus.swap_pending, 0);
        for (int k = 1; k <= 4; k++) begin
            pulse_tick();
            chk($sformatf("t4 seg1 idx %0d", k), bus.idx, k);
        end
        chk("t4 not yet stopped", bus.stopped, 0);
        pulse_tick();
        chk("t4 stopped", bus.stopped, 1);
        chk("t4 held idx", bus.idx, 4);
        pulse_tick();
        chk("t4 still held", bus.idx, 4);
        // coincident UPDATE+TICK uses the old divider
        do_reset();
        upd(0, 0, 7, 1, INF, 4, 1, 0);
        pulse_tick();
        chk("t5 idx1", bus.idx, 1);
        upd(1, 1, 7, 4, INF, 4, 1, 0);
        chk("t5 old div step", bus.idx, 2);
        for (int k = 1; k <= 8; k++) begin
            pulse_tick();
            chk($sformatf("t5 div4 k=%0d", k), bus.idx, 2 + k / 4);
        end
        // asynchronous reset in WAIT_WRAP
        do_reset();
        upd(0, 0, 7, 1, INF, 4, 1, 0);
        for (int k = 0; k < 5; k++) pulse_tick();
        upd(1, 0, 7, 1, INF, 4, 1, 0);
        idle();
        chk("t6 idx5", bus.idx, 5);
        chk("t6 pend", bus.swap_pending, 1);
        rst = 1'b1;
        #2;
        chk_zero("t6 async");
        idle();
        rst = 1'b0;
        idle();
        chk_zero("t6 released");
        upd(0, 0, 3, 1, INF, 0, 0, 0);
        pulse_tick();
        chk("t6 fresh idx", bus.idx, 1);
        chk("t6 fresh seg", bus.segment, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
